// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: port widths, result register,
// counter width and requester indices, plus the round-robin index helper.
package regfile_write_arbiter_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] RESULT_REG = 4'd15;
   localparam int WR_COUNT_W = 16;

   localparam int REQ_ALU    = 0;
   localparam int REQ_LOADER = 1;
   localparam int REQ_MEM    = 2;

   // Next requester index in rotation, wrapping at n without a modulo operator.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester/register-file bus of the write arbiter; the arbiter sits on the slave modport.
interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        ack;
   logic                    reg_write;
   logic [ADDR_W-1:0]       dir_WR;
   logic [DATA_W-1:0]       data_in;
   logic [WR_COUNT_W-1:0]   wr_count;
   logic                    prot_err;

   modport master (
      output req, req_addr, req_data,
      input  ack, reg_write, dir_WR, data_in, wr_count, prot_err
   );

   modport slave (
      input  req, req_addr, req_data,
      output ack, reg_write, dir_WR, data_in, wr_count, prot_err
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first eligible requester after last_grant wins.
module rr_priority_picker
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] eligible,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   int               idx;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = rr_next(int'(last_grant), N_REQ);
      cand        = IDX_W'(idx);
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'(idx);
         if (!grant_valid && eligible[cand]) begin
            grant_valid = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
         idx = rr_next(idx, N_REQ);
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port; outputs are registered on clk rise.
// Optional REGFILE_WRITE_ARBITER_R15_PROTECT_EN restricts register 15 writes to the ALU.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input logic                   clk,
   input logic                   rst,
   regfile_write_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]      eligible;
   logic [N_REQ-1:0]      grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_valid;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_data;

   logic                  reg_write_q, reg_write_d;
   logic [ADDR_W-1:0]     dir_wr_q, dir_wr_d;
   logic [DATA_W-1:0]     data_in_q, data_in_d;
   logic [N_REQ-1:0]      ack_q, ack_d;
   logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
   logic                  prot_err_q, prot_err_d;
`endif

   // A requester still showing its ack is dropping req and must not be granted twice.
   assign eligible = bus.req & ~ack_q;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .eligible    (eligible),
      .last_grant  (last_grant_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

   always_comb begin
      reg_write_d  = 1'b0;
      ack_d        = '0;
      dir_wr_d     = dir_wr_q;
      data_in_d    = data_in_q;
      wr_count_d   = wr_count_q;
      last_grant_d = last_grant_q;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
      prot_err_d   = 1'b0;
`endif
      if (grant_valid) begin
         ack_d        = grant;
         last_grant_d = grant_idx;
         dir_wr_d     = sel_addr;
         data_in_d    = sel_data;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
         // Rejected writes are still acknowledged so the requester can move on.
         if (grant_idx != IDX_W'(REQ_ALU) && sel_addr == ADDR_W'(RESULT_REG)) begin
            prot_err_d = 1'b1;
         end else begin
            reg_write_d = 1'b1;
            wr_count_d  = wr_count_q + WR_COUNT_W'(1);
         end
`else
         reg_write_d = 1'b1;
         wr_count_d  = wr_count_q + WR_COUNT_W'(1);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         dir_wr_q     <= '0;
         data_in_q    <= '0;
         ack_q        <= '0;
         wr_count_q   <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
         prot_err_q   <= 1'b0;
`endif
      end else begin
         reg_write_q  <= reg_write_d;
         dir_wr_q     <= dir_wr_d;
         data_in_q    <= data_in_d;
         ack_q        <= ack_d;
         wr_count_q   <= wr_count_d;
         last_grant_q <= last_grant_d;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
         prot_err_q   <= prot_err_d;
`endif
      end
   end

   assign bus.reg_write = reg_write_q;
   assign bus.dir_WR    = dir_wr_q;
   assign bus.data_in   = data_in_q;
   assign bus.ack       = ack_q;
   assign bus.wr_count  = wr_count_q;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
   assign bus.prot_err  = prot_err_q;
`else
   assign bus.prot_err  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic          r_req  [N];
   logic [AW-1:0] r_addr [N];
   logic [DW-1:0] r_data [N];

   int            m_last;
   logic [N-1:0]  m_ack;
   logic          m_rw;
   logic [AW-1:0] m_dir;
   logic [DW-1:0] m_data;
   logic [15:0]   m_cnt;
   logic          m_prot;

   logic [DW-1:0] rf [16];

   // Register file commits on the falling edge, as the real one does.
   always @(negedge clk) begin
      if (bus.reg_write) rf[bus.dir_WR] <= bus.data_in;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveBus();
      for (int i = 0; i < N; i++) begin
         bus.req[i]                = r_req[i];
         bus.req_addr[i*AW +: AW]  = r_addr[i];
         bus.req_data[i*DW +: DW]  = r_data[i];
      end
   endtask

   task automatic modelStep();
      int  g;
      bit  found;
      if (rst) begin
         m_last = N - 1;
         m_ack  = '0;
         m_rw   = 1'b0;
         m_dir  = '0;
         m_data = '0;
         m_cnt  = '0;
         m_prot = 1'b0;
      end else begin
         found = 0;
         g     = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && r_req[c] && !m_ack[c]) begin
               found = 1;
               g     = c;
            end
         end
         m_prot = 1'b0;
         if (found) begin
            m_ack  = '0;
            m_ack[g] = 1'b1;
            m_dir  = r_addr[g];
            m_data = r_data[g];
            m_last = g;
            m_rw   = 1'b1;
`ifdef REGFILE_WRITE_ARBITER_R15_PROTECT_EN
            if (g != 0 && r_addr[g] == 4'd15) begin
               m_rw   = 1'b0;
               m_prot = 1'b1;
            end
`endif
            if (m_rw) m_cnt = m_cnt + 16'd1;
         end else begin
            m_ack = '0;
            m_rw  = 1'b0;
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("reg_write", bus.reg_write, m_rw);
      checkOutput("dir_WR",    bus.dir_WR,    m_dir);
      checkOutput("data_in",   bus.data_in,   m_data);
      checkOutput("ack",       bus.ack,       m_ack);
      checkOutput("wr_count",  bus.wr_count,  m_cnt);
      checkOutput("prot_err",  bus.prot_err,  m_prot);
   endtask

   task automatic cycleStep();
      driveBus();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   // Requesters obey the contract: hold until acked, then drop or present the next write.
   task automatic applyStimulus(input int raisePct, input int dropPct);
      for (int i = 0; i < N; i++) begin
         if (r_req[i] && m_ack[i]) begin
            if ($urandom_range(0, 99) < dropPct) begin
               r_req[i] = 1'b0;
            end else begin
               r_addr[i] = AW'($urandom_range(0, 15));
               r_data[i] = $urandom;
            end
         end else if (!r_req[i] && $urandom_range(0, 99) < raisePct) begin
            r_req[i]  = 1'b1;
            r_addr[i] = AW'($urandom_range(0, 15));
            r_data[i] = $urandom;
         end
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) r_req[i] = 1'b0;
      cycleStep();
      cycleStep();
      rst = 1'b0;
   endtask

   initial begin
      int acks;
      int b2b;
      logic prev;

      for (int i = 0; i < N; i++) begin
         r_req[i]  = 1'b0;
         r_addr[i] = '0;
         r_data[i] = '0;
      end
      for (int i = 0; i < 16; i++) rf[i] = '0;
      m_last = N - 1;
      m_ack  = '0;
      m_rw   = 1'b0;
      m_dir  = '0;
      m_data = '0;
      m_cnt  = '0;
      m_prot = 1'b0;
      @(negedge clk);

      $display("[TB] reset then idle");
      doReset();
      repeat (5) cycleStep();
      checkOutput("idle_wr_count",  bus.wr_count,  16'd0);
      checkOutput("idle_reg_write", bus.reg_write, 1'b0);
      checkOutput("idle_dir_WR",    bus.dir_WR,    4'd0);
      checkOutput("idle_data_in",   bus.data_in,   32'd0);
      checkOutput("idle_ack",       bus.ack,       3'b000);

      $display("[TB] single write");
      r_req[1]  = 1'b1;
      r_addr[1] = 4'd3;
      r_data[1] = 32'h0000_00A5;
      cycleStep();
      checkOutput("single_reg_write", bus.reg_write, 1'b1);
      checkOutput("single_dir_WR",    bus.dir_WR,    4'd3);
      checkOutput("single_data_in",   bus.data_in,   32'hA5);
      checkOutput("single_ack",       bus.ack,       3'b010);
      checkOutput("single_wr_count",  bus.wr_count,  16'd1);
      r_req[1] = 1'b0;
      cycleStep();
      checkOutput("single_rf3",       rf[3],         32'hA5);
      checkOutput("single_idle_after", bus.reg_write, 1'b0);

      $display("[TB] three-way contention");
      doReset();
      r_addr[0] = 4'd1;  r_data[0] = 32'h1111;
      r_addr[1] = 4'd2;  r_data[1] = 32'h2222;
      r_addr[2] = 4'd15; r_data[2] = 32'h3333;
      for (int i = 0; i < N; i++) r_req[i] = 1'b1;
      for (int k = 0; k < N; k++) begin
         cycleStep();
         checkOutput("contention_ack", bus.ack, 64'd1 << k);
         r_req[k] = 1'b0;
      end
      cycleStep();
      checkOutput("contention_wr_count", bus.wr_count, 16'd3);
      checkOutput("contention_rf15",     rf[15],       32'h3333);

      $display("[TB] single requester streaming");
      doReset();
      r_req[2]  = 1'b1;
      r_addr[2] = 4'd7;
      r_data[2] = $urandom;
      acks = 0;
      b2b  = 0;
      prev = 1'b0;
      repeat (10) begin
         cycleStep();
         if (bus.ack[2]) begin
            acks++;
            if (prev) b2b++;
            r_data[2] = $urandom;
         end
         prev = bus.ack[2];
      end
      checkOutput("stream_ack_count", acks, 5);
      checkOutput("stream_back2back", b2b,  0);

      $display("[TB] reset mid-stream");
      doReset();
      applyStimulus(100, 0);
      repeat (2) begin
         cycleStep();
         applyStimulus(100, 0);
      end
      rst = 1'b1;
      cycleStep();
      checkOutput("midrst_reg_write", bus.reg_write, 1'b0);
      checkOutput("midrst_ack",       bus.ack,       3'b000);
      checkOutput("midrst_wr_count",  bus.wr_count,  16'd0);
      rst = 1'b0;
      cycleStep();
      checkOutput("midrst_regrant_ack", bus.ack,      3'b001);
      checkOutput("midrst_regrant_cnt", bus.wr_count, 16'd1);

      $display("[TB] randomized traffic");
      doReset();
      repeat (3000) begin
         applyStimulus(30, 60);
         rst = ($urandom_range(0, 199) == 0);
         cycleStep();
         rst = 1'b0;
      end

      $display("[TB] write counter wrap");
      doReset();
      repeat (65535) begin
         applyStimulus(100, 0);
         cycleStep();
      end
      checkOutput("wrap_ffff", bus.wr_count, 16'hFFFF);
      applyStimulus(100, 0);
      cycleStep();
      checkOutput("wrap_zero", bus.wr_count, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
